// File: rtl/sgm_display_driver.sv
// Multiplexed 4-digit + colon seven-segment driver with double-buffered data,
// dead-time blanking on position changes. Optional LEADING_ZERO_BLANK_EN.
module sgm_display_driver #(
  parameter int unsigned DEAD_CYCLES = 2,
  parameter logic [2:0]  POS_MAX     = 3'b100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  select_afisare,
  input  logic [15:0] digit_in,
  input  logic        colon_in,
  input  logic        upd_req,
  output logic        upd_ack,
  output logic [4:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        select_err
);

  localparam logic [3:0] DEAD = 4'(DEAD_CYCLES);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [2:0]  prev_sel;
  logic [15:0] shadow_d, active_d, active_d_n;
  logic        shadow_c, active_c, active_c_n;
  logic        pending;
  logic        illegal, changed, boundary, xfer;
  logic [3:0]  digit;
  logic [4:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  assign illegal  = select_afisare > POS_MAX;
  assign changed  = select_afisare != prev_sel;
  assign boundary = (select_afisare == 3'd0) && (prev_sel != 3'd0);
  assign xfer     = boundary && pending;

  // Decode from the post-transfer data so upd_ack and the new image align.
  assign active_d_n = xfer ? shadow_d : active_d;
  assign active_c_n = xfer ? shadow_c : active_c;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (changed) begin
      cnt_n   = DEAD;
      state_n = (DEAD == 4'd0) ? SHOW : BLANK;
    end else if (state == BLANK) begin
      if (cnt <= 4'd1) begin
        cnt_n   = 4'd0;
        state_n = SHOW;
      end else begin
        cnt_n = cnt - 4'd1;
      end
    end
  end

  always_comb begin
    case (select_afisare[1:0])
      2'd0:    digit = active_d_n[15:12];
      2'd1:    digit = active_d_n[11:8];
      2'd2:    digit = active_d_n[7:4];
      default: digit = active_d_n[3:0];
    endcase
  end

  always_comb begin
    an_n  = 5'b11111;
    seg_n = 7'b1111111;
    dp_n  = 1'b1;
    if (state_n == SHOW && !illegal) begin
      if (select_afisare == 3'd4) begin
        an_n[4] = 1'b0;
        dp_n    = ~active_c_n;
      end else if (select_afisare < 3'd4) begin
        an_n[select_afisare[1:0]] = 1'b0;
        seg_n = decode(digit);
`ifdef LEADING_ZERO_BLANK_EN
        if (select_afisare == 3'd0 && digit == 4'd0) seg_n = 7'b1111111;
`endif
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= BLANK;
      cnt        <= DEAD;
      prev_sel   <= 3'd0;
      shadow_d   <= 16'd0;
      shadow_c   <= 1'b0;
      active_d   <= 16'd0;
      active_c   <= 1'b0;
      pending    <= 1'b0;
      upd_ack    <= 1'b0;
      an         <= 5'b11111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      select_err <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      prev_sel <= select_afisare;
      active_d <= active_d_n;
      active_c <= active_c_n;
      upd_ack  <= xfer;
      // A coincident request re-arms pending after the old shadow moves out.
      if (upd_req) begin
        shadow_d <= digit_in;
        shadow_c <= colon_in;
        pending  <= 1'b1;
      end else if (xfer) begin
        pending  <= 1'b0;
      end
      an  <= an_n;
      seg <= seg_n;
      dp  <= dp_n;
      if (illegal) select_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sgm_display_driver.sv
// Randomized bench for sgm_display_driver against an edge-indexed reference model.
module tb_sgm_display_driver;

  localparam int DEAD    = 2;
  localparam int POS_MAX = 4;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  logic        clk, reset;
  logic [2:0]  select_afisare;
  logic [15:0] digit_in;
  logic        colon_in, upd_req;
  logic        upd_ack, dp, select_err;
  logic [4:0]  an;
  logic [6:0]  seg;

  int n_cmp, n_bad;

  // reference model state
  int          e, last_chg, m_prev;
  logic [15:0] m_sh, m_act;
  logic        m_shc, m_actc, m_pend, m_err, m_ack;
  logic [4:0]  x_an;
  logic [6:0]  x_seg;
  logic        x_dp;

  sgm_display_driver #(.DEAD_CYCLES(DEAD), .POS_MAX(3'(POS_MAX))) dut (
    .clock(clk), .reset(reset), .select_afisare(select_afisare),
    .digit_in(digit_in), .colon_in(colon_in), .upd_req(upd_req),
    .upd_ack(upd_ack), .an(an), .seg(seg), .dp(dp), .select_err(select_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    last_chg = e; m_prev = 0;
    m_sh = 0; m_shc = 0; m_act = 0; m_actc = 0;
    m_pend = 0; m_err = 0; m_ack = 0;
    x_an = 5'h1F; x_seg = 7'h7F; x_dp = 1'b1;
  endtask

  task automatic model_edge(input int s, input logic req, input logic [15:0] d, input logic c);
    bit bnd, ill, vis;
    int dig;
    e++;
    ill = s > POS_MAX;
    bnd = (s == 0) && (m_prev != 0);
    if (s != m_prev) last_chg = e;
    m_ack = bnd && m_pend;
    if (bnd && m_pend) begin m_act = m_sh; m_actc = m_shc; m_pend = 0; end
    if (req) begin m_sh = d; m_shc = c; m_pend = 1; end
    m_prev = s;
    if (ill) m_err = 1;
    vis = (e - last_chg >= DEAD) && !ill;
    x_an = 5'h1F; x_seg = 7'h7F; x_dp = 1'b1;
    if (vis) begin
      x_an = 5'h1F ^ (5'd1 << s);
      if (s == 4) x_dp = ~m_actc;
      else begin
        dig = int'(m_act >> (12 - 4 * s)) & 15;
        x_seg = SEG_TAB[dig];
`ifdef LEADING_ZERO_BLANK_EN
        if (s == 0 && dig == 0) x_seg = 7'h7F;
`endif
      end
    end
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".an"},  32'(an),         32'(x_an));
    chk({ctx, ".seg"}, 32'(seg),        32'(x_seg));
    chk({ctx, ".dp"},  32'(dp),         32'(x_dp));
    chk({ctx, ".ack"}, 32'(upd_ack),    32'(m_ack));
    chk({ctx, ".err"}, 32'(select_err), 32'(m_err));
  endtask

  task automatic step(input string ctx, input int s, input logic req,
                      input logic [15:0] d, input logic c);
    select_afisare = 3'(s); upd_req = req; digit_in = d; colon_in = c;
    @(posedge clk);
    model_edge(s, req, d, c);
    #1;
    check_outputs(ctx);
    upd_req = 1'b0;
  endtask

  task automatic do_reset();
    select_afisare = 0; upd_req = 0;
    reset = 1'b1;
    #1;
    chk("rst.an",  32'(an),         32'h1F);
    chk("rst.seg", 32'(seg),        32'h7F);
    chk("rst.dp",  32'(dp),         32'h1);
    chk("rst.ack", 32'(upd_ack),    32'h0);
    chk("rst.err", 32'(select_err), 32'h0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int acks, cur, hold;
    clk = 0; reset = 0; n_cmp = 0; n_bad = 0; e = 0;
    select_afisare = 0; digit_in = 0; colon_in = 0; upd_req = 0;
    model_reset();
    #2 do_reset();

    // Power-up with select held at 0: two blank clocks then digit 0.
    for (int i = 0; i < 4; i++) step("pwrup", 0, 0, 16'h0, 0);

    // Load 1234/colon while at position 2, transfer on the 4->0 wrap.
    repeat (3) step("load", 2, 0, 16'h0, 0);
    step("load", 2, 1, 16'h1234, 1);
    acks = 0;
    foreach (SEG_TAB[i]) if (i < 3) begin
      for (int k = 0; k < 3; k++) begin
        step("wrap", (i == 0) ? 3 : (i == 1) ? 4 : 0, 0, 16'h0, 0);
        if (upd_ack) acks++;
      end
    end
    chk("ack_count", 32'(acks), 32'd1);
    for (int p = 1; p <= 4; p++) repeat (3) step("scan", p, 0, 16'h0, 0);

    // Quick 1->2->3 stepping: blanking restarts from the 3.
    repeat (3) step("dead", 1, 0, 16'h0, 0);
    step("dead", 2, 0, 16'h0, 0);
    repeat (4) step("dead", 3, 0, 16'h0, 0);
    chk("dead.an3", 32'(an), 32'b10111);

    // Dash and leading-zero handling.
    repeat (2) step("lz", 4, 0, 16'h0, 0);
    step("lz", 4, 1, 16'h0A09, 0);
    for (int p = 0; p <= 4; p++) repeat (3) step("lz", p, 0, 16'h0, 0);
    for (int p = 0; p <= 3; p++) repeat (3) step("lz2", p, 0, 16'h0, 0);

    // Random legal scanning with random updates.
    cur = 0; hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        cur  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : (cur + 1) % 5;
        hold = $urandom_range(1, 5);
      end
      hold--;
      step("rnd", cur, ($urandom_range(0, 5) == 0), 16'($urandom), 1'($urandom));
    end

    // Asynchronous reset mid-operation with an update pending.
    step("arst", 2, 1, 16'h5678, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst.an",  32'(an),      32'h1F);
    chk("arst.seg", 32'(seg),     32'h7F);
    chk("arst.dp",  32'(dp),      32'h1);
    chk("arst.ack", 32'(upd_ack), 32'h0);
    do_reset();
    for (int p = 1; p <= 5; p++) repeat (3) step("postrst", p % 5, 0, 16'h0, 0);
    repeat (3) step("postrst", 1, 0, 16'h0, 0);

    // Illegal select: blank, sticky error, display resumes.
    step("ill", 5, 0, 16'h0, 0);
    for (int p = 0; p <= 4; p++) repeat (3) step("ill_rec", p, 0, 16'h0, 0);

    // Random mix including illegal selects.
    for (int i = 0; i < 400; i++)
      step("rndx", $urandom_range(0, 7), ($urandom_range(0, 4) == 0), 16'($urandom), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sgm_display_driver.md
SGM_DISPLAY_DRIVER -- requirements
Module: sgm_display_driver

Interface
REQ-001 Parameter DEAD_CYCLES, default 2, sets the number of all-anodes-off clocks inserted after every position change (legal range 0..15).
REQ-002 Parameter POS_MAX, default 3'b100, sets the highest legal position index. Legal indices are 0..POS_MAX.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 select_afisare  input  3  current display position from the position counter: 0..3 = digits, 4 = colon.
REQ-006 digit_in  input  16  four BCD digits; [15:12] = position 0 (leftmost) ... [3:0] = position 3.
REQ-007 colon_in  input  1  colon state that accompanies digit_in.
REQ-008 upd_req  input  1  single-cycle request to load digit_in/colon_in.
REQ-009 upd_ack  output  1  single-cycle pulse when the loaded data becomes visible.
REQ-010 an  output  5  active-low anode enables, one bit per position.
REQ-011 seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-012 dp  output  1  active-low colon/decimal point.
REQ-013 select_err  output  1  sticky flag: an illegal select value was seen.

Function
REQ-014 Data path: shadow register, then active register. Only the active register is decoded.
REQ-015 upd_req high: capture digit_in/colon_in into the shadow register and set pending. Further requests while pending overwrite the shadow; pending stays 1.
REQ-016 Frame boundary: the sampled select_afisare equals 0 while the registered previous value is nonzero.
REQ-017 At a frame boundary with pending=1: copy shadow to active, clear pending, and assert upd_ack for exactly one cycle.
REQ-018 upd_req coincident with a frame boundary: the old shadow transfers and upd_ack pulses; the new data is captured and pending remains 1.
REQ-019 FSM states BLANK and SHOW. A sampled select differing from the previous value forces BLANK and loads the dead counter with DEAD_CYCLES.
REQ-020 In BLANK: an=5'b11111, seg=7'b1111111, dp=1. Each clock decrements the counter; at zero the FSM goes to SHOW. If DEAD_CYCLES=0, BLANK is skipped.
REQ-021 Select change mid-BLANK restarts the dead counter. Blanking time is measured from the latest change.
REQ-022 In SHOW for position p (0..3): an bit p is low and the others high; seg = decode of active digit p; dp=1.
REQ-023 In SHOW for position 4: an[4] low; seg=7'b1111111; dp=~colon_active.
REQ-024 Decode: standard patterns for 0..9. BCD 10..15 displays a dash (seg=7'b0111111).
REQ-025 All outputs are registered. Outputs reflect the select value sampled at edge k no earlier than edge k+DEAD_CYCLES.
REQ-026 A select value greater than POS_MAX forces outputs blank and sets select_err, which stays set until reset. It does not count as a frame boundary.

Reset
REQ-027 Reset values: an=5'b11111, seg=7'b1111111, dp=1, upd_ack=0, select_err=0.
REQ-028 Reset also clears shadow, active and pending to 0, sets the previous select to 0, and enters BLANK with the dead counter set to DEAD_CYCLES.
REQ-029 Reset asserted mid-operation aborts any pending update without an upd_ack pulse. Outputs go blank immediately, without waiting for a clock edge.

Configuration
REQ-030 Macro LEADING_ZERO_BLANK_EN defined: position 0 whose active digit is 0 shows seg=7'b1111111 (anode still enabled).
REQ-031 Macro LEADING_ZERO_BLANK_EN undefined: position 0 with digit 0 shows the normal "0" pattern (7'b1000000). All other behaviour is identical in both builds.

Verification
REQ-032 Reset release, select held at 0, DEAD_CYCLES=2 -> an=11111 for 2 clocks, then an=11110 and seg=1000000 (digit 0).
REQ-033 upd_req with digit_in=16'h1234 and colon_in=1 while select=2, then select sequence 3,4,0 -> upd_ack pulses once on the 4->0 sample. The next SHOW at positions 0..4 gives seg 1111001, 0100100, 0110000, 0011001, and dp=0 at position 4.
REQ-034 Select stepping 1->2, then 2->3 one clock later -> blanking is extended to 2 clocks after the 3 is sampled; an never shows position 2.
REQ-035 Select=5 for one clock -> outputs blank and select_err=1. Select then returns to 0..4 -> normal display resumes and select_err stays 1 until reset.
REQ-036 digit_in=16'h0A09 loaded -> position 0 blank with LEADING_ZERO_BLANK_EN (1000000 without it), position 1 shows a dash (0111111), position 3 shows 0010000.
